// File: rtl/muldiv_seq_if.sv
// ============================================================================
// muldiv_seq_if : command/result handshake and ALU operand bus of muldiv_seq
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface muldiv_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic [WIDTH-1:0] alu_first;
  logic [WIDTH-1:0] alu_second;
  logic [3:0]       alu_select;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  // alu_zero carries no information the core needs, so the core side omits it
  modport slave (
    input  start, op, a, b, alu_out,
    output busy, done, hi, lo, div_by_zero, alu_first, alu_second, alu_select
  );

  modport master (
    output start, op, a, b, alu_out, alu_zero,
    input  busy, done, hi, lo, div_by_zero, alu_first, alu_second, alu_select
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// muldiv_seq : sequential unsigned MULTU/DIVU into HI/LO via an external ALU
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  muldiv_seq_if.slave  bus
);

  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic             r_op;
  logic [WIDTH-1:0] r_opnd;   // multiplicand or divisor, captured at accept
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_sh;
  logic             w_carry;
  logic             w_q;

  assign w_sh    = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_carry = (bus.alu_out < r_hi);
  // hi[31] set means the shifted partial remainder is 33 bits wide and always exceeds the divisor
  assign w_q     = r_hi[WIDTH-1] | (w_sh >= r_opnd);

  always_comb begin
    bus.alu_first  = '0;
    bus.alu_second = '0;
    bus.alu_select = C_ALU_ADD;
    if (r_state == S_RUN) begin
      if (r_op) begin
        bus.alu_first  = w_sh;
        bus.alu_second = r_opnd;
        bus.alu_select = C_ALU_SUB;
      end else begin
        bus.alu_first  = r_hi;
        bus.alu_second = r_lo[0] ? r_opnd : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (bus.start) begin
            r_op   <= bus.op;
            r_opnd <= bus.b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (bus.op && (bus.b == '0)) begin
              r_hi    <= bus.a;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= bus.a;
              r_dbz   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_op) begin
            r_hi <= w_q ? bus.alu_out : w_sh;
            r_lo <= {r_lo[WIDTH-2:0], w_q};
          end else begin
            {r_hi, r_lo} <= {w_carry, bus.alu_out, r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// tb_muldiv_seq : vector table, corner sequences and random ops vs. arithmetic model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   bad_sel;
  int   bad_idle;

  muldiv_seq_if #(.WIDTH(32)) bus();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the datapath alu32bit: ADD/SUB only
  always_comb begin
    bus.alu_out  = (bus.alu_select == 4'b0110) ? (bus.alu_first - bus.alu_second)
                                               : (bus.alu_first + bus.alu_second);
    bus.alu_zero = (bus.alu_out == 32'd0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.alu_select !== 4'b0010 && bus.alu_select !== 4'b0110) bad_sel++;
      if (!bus.busy && (bus.alu_first !== 32'd0 || bus.alu_second !== 32'd0 ||
                        bus.alu_select !== 4'b0010)) bad_idle++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic void ref_op(input logic iop, input logic [31:0] ia, input logic [31:0] ib,
                                 output logic [31:0] h, output logic [31:0] l,
                                 output logic z, output int lat);
    logic [63:0] p;
    z = 1'b0;
    lat = 33;
    if (!iop) begin
      p = {32'd0, ia} * {32'd0, ib};
      h = p[63:32];
      l = p[31:0];
    end else if (ib == 32'd0) begin
      h = ia;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
      lat = 1;
    end else begin
      h = ia % ib;
      l = ia / ib;
    end
  endfunction

  // Issues one op and returns the outputs seen in the done cycle
  task automatic do_op(input logic iop, input logic [31:0] ia, input logic [31:0] ib,
                       output logic [31:0] ohi, output logic [31:0] olo,
                       output logic odbz, output logic obusy, output int olat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = iop;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    olat = 1;
    @(negedge clk);
    while (!bus.done && olat < 100) begin
      @(negedge clk);
      olat++;
    end
    ohi   = bus.hi;
    olo   = bus.lo;
    odbz  = bus.div_by_zero;
    obusy = bus.busy;
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          elat;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] g_hi, g_lo, m_hi, m_lo;
  logic        g_dbz, g_busy, m_dbz;
  int          g_lat, m_lat, ndone, wait_cnt;

  initial begin
    checks = 0; failures = 0; bad_sel = 0; bad_idle = 0;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;

    vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0, 33};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0, 33};
    vecs[2] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 33};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[5] = '{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1, 1};
    vecs[6] = '{1'b0, 32'd2,          32'd3,          32'd0,          32'd6,          1'b0, 33};
    vecs[7] = '{1'b0, 32'h0001_0000,  32'h0001_0000,  32'd1,          32'd0,          1'b0, 33};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    chk("rst_alu_sel", {28'd0, bus.alu_select}, 32'd2);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, g_hi, g_lo, g_dbz, g_busy, g_lat);
      chk($sformatf("vec%0d_hi", i), g_hi, vecs[i].ehi);
      chk($sformatf("vec%0d_lo", i), g_lo, vecs[i].elo);
      chk($sformatf("vec%0d_dbz", i), {31'd0, g_dbz}, {31'd0, vecs[i].edbz});
      chk($sformatf("vec%0d_lat", i), g_lat, vecs[i].elat);
      chk($sformatf("vec%0d_busy_at_done", i), {31'd0, g_busy}, 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("vec%0d_busy_after", i), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("vec%0d_hold_lo", i), bus.lo, vecs[i].elo);
    end

    // start held high for 40 cycles: exactly one completion in the window
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd3; bus.b = 32'd3;
    ndone = 0; g_lo = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        g_lo = bus.lo;
      end
    end
    bus.start = 1'b0;
    chk("held_start_done_count", ndone, 32'd1);
    chk("held_start_lo", g_lo, 32'd9);
    wait_cnt = 0;
    while (bus.busy && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("held_start_drain", {31'd0, bus.busy}, 32'd0);

    // start pulse with other operands in the middle of a DIVU
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cnt = 0;
    while (!bus.done && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("midrun_start_lo", bus.lo, 32'd142);
    chk("midrun_start_hi", bus.hi, 32'd6);
    @(negedge clk);

    // asynchronous reset at iteration 10 of a DIVU
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_rst_done", {31'd0, bus.done}, 32'd0);
    chk("async_rst_hi", bus.hi, 32'd0);
    chk("async_rst_lo", bus.lo, 32'd0);
    chk("async_rst_alu_first", bus.alu_first, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 32'd5, 32'd5, g_hi, g_lo, g_dbz, g_busy, g_lat);
    chk("post_rst_lo", g_lo, 32'd25);
    chk("post_rst_lat", g_lat, 32'd33);

    // random ops against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      logic        r_op_t;
      logic [31:0] ra, rb;
      r_op_t = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      ref_op(r_op_t, ra, rb, m_hi, m_lo, m_dbz, m_lat);
      do_op(r_op_t, ra, rb, g_hi, g_lo, g_dbz, g_busy, g_lat);
      chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, r_op_t, ra, rb), g_hi, m_hi);
      chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, r_op_t, ra, rb), g_lo, m_lo);
      chk($sformatf("rnd%0d_dbz", i), {31'd0, g_dbz}, {31'd0, m_dbz});
      chk($sformatf("rnd%0d_lat", i), g_lat, m_lat);
    end

    @(negedge clk);
    chk("alu_select_legal", bad_sel, 32'd0);
    chk("alu_idle_values", bad_idle, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
